// File: rtl/secuenciador_reset_pkg.sv
// secuenciador_reset_pkg: state encoding and default timing shared by the reset sequencer and its consumers
package secuenciador_reset_pkg;
    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } estado_t;
    localparam int HOLD_DEF   = 16;
    localparam int ETAPAS_DEF = 3;
    localparam int GAP_DEF    = 4;
    localparam int CNT_W_DEF  = 8;
endpackage

// File: rtl/secuenciador_reset_contador_retardo.sv
// contador_retardo: up-counter with sync clear and terminal-count compare, shared by the hold and gap phases
module contador_retardo #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] limite,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;
    assign tc = cnt == limite;
    // count up, restarting from zero on block reset or an explicit clear
    always_ff @(posedge clk) begin
        if (!reset || clr) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/secuenciador_reset.sv
// secuenciador_reset: stretches a reset request into a staged domain release followed by system release and an init pulse
module secuenciador_reset
    import secuenciador_reset_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_DEF,
    parameter int N_ETAPAS    = ETAPAS_DEF,
    parameter int GAP_CYCLES  = GAP_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pulso_reset,
    output logic [N_ETAPAS-1:0] rst_etapa,
    output logic                rst_sistema,
    output logic                listo,
    output logic                inicio_init,
    output logic [7:0]          cuenta_reinicios
);
    estado_t          estado;
    logic             tc;
    logic [CNT_W-1:0] limite;
    assign limite = estado == ASSERT ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);
    contador_retardo #(.CNT_W(CNT_W)) u_retardo (
        .clk    (clk),
        .reset  (reset),
        .clr    (pulso_reset || tc || estado == DONE),
        .limite (limite),
        .tc     (tc)
    );
    // sequencer: domains release lowest index first by shifting zeros in from bit 0
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado           <= ASSERT;
            rst_etapa        <= '1;
            rst_sistema      <= 1'b1;
            listo            <= 1'b0;
            inicio_init      <= 1'b0;
            cuenta_reinicios <= '0;
        end else if (pulso_reset) begin
            estado           <= ASSERT;
            rst_etapa        <= '1;
            rst_sistema      <= 1'b1;
            listo            <= 1'b0;
            inicio_init      <= 1'b0;
            cuenta_reinicios <= cuenta_reinicios + {7'd0, cuenta_reinicios != 8'hff};
        end else begin
            inicio_init <= 1'b0;
            if (tc && estado == ASSERT) begin
                rst_etapa <= rst_etapa << 1;
                estado    <= RELEASE;
            end else if (tc && estado == RELEASE && rst_etapa != '0) begin
                rst_etapa <= rst_etapa << 1;
            end else if (tc && estado == RELEASE) begin
                rst_sistema <= 1'b0;
                listo       <= 1'b1;
                inicio_init <= 1'b1;
                estado      <= DONE;
            end
        end
    end
endmodule
